// File: rtl/tqvp_nkanderson_wdt_escalator.sv
// rtl/tqvp_nkanderson_wdt_escalator.sv - watchdog timeout escalator: warn, grace window, reset pulse
// Sits behind the watchdog and turns an unserviced timeout into a PMOD reset pulse.
`timescale 1ns/1ps

module tqvp_nkanderson_wdt_escalator #(
  parameter logic [15:0] GRACE_DEFAULT = 16'd1000,
  parameter logic [7:0]  PULSE_DEFAULT = 8'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wdt_timeout,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WARN  = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [5:0] ADDR_GRACE  = 6'd0;
  localparam logic [5:0] ADDR_PULSE  = 6'd1;
  localparam logic [5:0] ADDR_CTRL   = 6'd2;
  localparam logic [5:0] ADDR_STATUS = 6'd3;

  state_t      state;
  state_t      state_next;
  logic        armed;
  logic [7:0]  reset_count;
  logic [15:0] grace_reg;
  logic [7:0]  pulse_reg;
  logic [15:0] grace_cnt;
  logic [15:0] grace_cnt_next;
  logic [7:0]  pulse_cnt;
  logic [7:0]  pulse_cnt_next;
  logic        count_inc;
  logic        wr_en;
  logic        wr_byte;
  logic        wr_grace;
  logic        wr_pulse;
  logic        wr_ctrl;
  logic [7:0]  pulse_len;
  logic        sys_reset_n;
  logic        warn;
  logic        unused_ok;

  assign wr_en     = (data_write_n != 2'b11);
  assign wr_byte   = (data_write_n == 2'b00);
  assign wr_grace  = wr_en && (address == ADDR_GRACE);
  assign wr_pulse  = wr_en && (address == ADDR_PULSE);
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign pulse_len = (pulse_reg == 8'd0) ? 8'd1 : pulse_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counters are snapshotted on entry, so register writes only matter at the next load.
  always_comb begin
    state_next     = state;
    grace_cnt_next = grace_cnt;
    pulse_cnt_next = pulse_cnt;
    count_inc      = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && wdt_timeout) begin
          state_next     = S_WARN;
          grace_cnt_next = grace_reg;
        end
      end
      S_WARN: begin
        if (!wdt_timeout || !armed) begin
          state_next = S_IDLE;
        end else if (grace_cnt == 16'd0) begin
          state_next     = S_PULSE;
          pulse_cnt_next = pulse_len;
          count_inc      = 1'b1;
        end else begin
          grace_cnt_next = grace_cnt - 16'd1;
        end
      end
      S_PULSE: begin
        pulse_cnt_next = pulse_cnt - 8'd1;
        if (pulse_cnt <= 8'd1) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!wdt_timeout) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grace_cnt   <= 16'd0;
      pulse_cnt   <= 8'd0;
      armed       <= 1'b0;
      reset_count <= 8'd0;
      grace_reg   <= GRACE_DEFAULT;
      pulse_reg   <= PULSE_DEFAULT;
    end else begin
      grace_cnt <= grace_cnt_next;
      pulse_cnt <= pulse_cnt_next;
      if (wr_grace) begin
        grace_reg <= wr_byte ? {8'd0, data_in[7:0]} : data_in[15:0];
      end
      if (wr_pulse) begin
        pulse_reg <= data_in[7:0];
      end
      if (wr_ctrl) begin
        armed <= data_in[0];
      end
      // A software clear beats a same-cycle escalation.
      if (wr_ctrl && data_in[1]) begin
        reset_count <= 8'd0;
      end else if (count_inc && (reset_count != 8'hFF)) begin
        reset_count <= reset_count + 8'd1;
      end
    end
  end

  assign sys_reset_n    = (state != S_PULSE);
  assign warn           = (state == S_WARN);
  assign user_interrupt = warn;
  assign uo_out         = {5'd0, warn, sys_reset_n, 1'b0};

  assign data_ready = (data_read_n != 2'b11);

  always_comb begin
    data_out = 32'd0;
    if (data_ready) begin
      case (address)
        ADDR_GRACE:  data_out = {16'd0, grace_reg};
        ADDR_PULSE:  data_out = {24'd0, pulse_reg};
        ADDR_CTRL:   data_out = 32'd0;
        ADDR_STATUS: data_out = {16'd0, reset_count, 5'd0, armed, state};
        default:     data_out = 32'hFFFF_FFFF;
      endcase
    end
  end

  assign unused_ok = &{1'b0, ui_in, data_in[31:16]};

endmodule

// File: tb/tb_tqvp_nkanderson_wdt_escalator.sv
// tb/tb_tqvp_nkanderson_wdt_escalator.sv - self-checking bench for the watchdog escalator
// Reset read table, directed escalation sequences, then randomized traffic against a cycle-count model.
`timescale 1ns/1ps

module tb_tqvp_nkanderson_wdt_escalator;

  logic        clk;
  logic        rst_n;
  logic        wdt_timeout;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int checks = 0;
  int errors = 0;
  int cnt_warn = 0;
  int cnt_pulse = 0;

  // Model: phase 0 idle, 1 warn, 2 pulse, 3 hold; timing tracked as cycles spent in the phase.
  int          m_state;
  bit          m_armed;
  int          m_count;
  logic [15:0] m_grace;
  logic [7:0]  m_pulse;
  int          m_gload;
  int          m_pload;
  int          m_warn_cycles;
  int          m_pulse_cycles;

  tqvp_nkanderson_wdt_escalator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wdt_timeout    (wdt_timeout),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [1:0]  rd;
    logic        ready;
    logic [31:0] data;
  } rvec_t;

  rvec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state        = 0;
    m_armed        = 1'b0;
    m_count        = 0;
    m_grace        = 16'd1000;
    m_pulse        = 8'd16;
    m_gload        = 0;
    m_pload        = 0;
    m_warn_cycles  = 0;
    m_pulse_cycles = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a);
    case (a)
      6'd0:    return {16'd0, m_grace};
      6'd1:    return {24'd0, m_pulse};
      6'd2:    return 32'd0;
      6'd3:    return {16'd0, 8'(m_count), 5'd0, m_armed, 2'(m_state)};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Advance the model over one clock edge using the inputs held during the finished cycle.
  task automatic model_edge();
    int ns;
    bit inc;
    bit clr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ns  = m_state;
    inc = 1'b0;
    clr = 1'b0;
    case (m_state)
      0: if (m_armed && wdt_timeout) begin
        ns = 1;
        m_gload = int'(m_grace);
        m_warn_cycles = 1;
      end
      1: if (!wdt_timeout || !m_armed) begin
        ns = 0;
      end else if (m_warn_cycles == m_gload + 1) begin
        ns = 2;
        m_pload = (m_pulse == 8'd0) ? 1 : int'(m_pulse);
        m_pulse_cycles = 1;
        inc = 1'b1;
      end else begin
        m_warn_cycles++;
      end
      2: if (m_pulse_cycles == m_pload) ns = 3;
         else m_pulse_cycles++;
      default: if (!wdt_timeout) ns = 0;
    endcase
    if (data_write_n != 2'b11) begin
      case (address)
        6'd0: m_grace = (data_write_n == 2'b00) ? {8'd0, data_in[7:0]} : data_in[15:0];
        6'd1: m_pulse = data_in[7:0];
        6'd2: begin
          m_armed = data_in[0];
          clr = data_in[1];
        end
        default: ;
      endcase
    end
    if (inc && m_count < 255) m_count++;
    if (clr) m_count = 0;
    m_state = ns;
  endtask

  task automatic check_outputs();
    logic [7:0]  want_uo;
    logic        want_ready;
    logic [31:0] want_data;
    want_uo    = {5'd0, m_state == 1, m_state != 2, 1'b0};
    want_ready = (data_read_n != 2'b11);
    want_data  = want_ready ? model_read(address) : 32'd0;
    chk("uo_out", {24'd0, uo_out}, {24'd0, want_uo});
    chk("user_interrupt", {31'd0, user_interrupt}, {31'd0, m_state == 1});
    chk("data_ready", {31'd0, data_ready}, {31'd0, want_ready});
    chk("data_out", data_out, want_data);
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, then crosses one edge.
  task automatic tick();
    #1;
    check_outputs();
    if (user_interrupt) cnt_warn++;
    if (!uo_out[1]) cnt_pulse++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_bus();
    address      = 6'd0;
    data_in      = 32'd0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    address      = a;
    data_in      = d;
    data_write_n = w;
    tick();
    idle_bus();
  endtask

  task automatic read_check(input logic [5:0] a, input logic [31:0] want, input string name);
    address     = a;
    data_read_n = 2'b10;
    #1;
    chk(name, data_out, want);
    tick();
    idle_bus();
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  w;
    logic [5:0]  ra;
    int          r;

    rst_n       = 1'b0;
    wdt_timeout = 1'b0;
    ui_in       = 8'hA5;
    idle_bus();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    tbl[0] = '{6'd3,  2'b10, 1'b1, 32'h0000_0000};
    tbl[1] = '{6'd0,  2'b10, 1'b1, 32'd1000};
    tbl[2] = '{6'd1,  2'b01, 1'b1, 32'd16};
    tbl[3] = '{6'd5,  2'b00, 1'b1, 32'hFFFF_FFFF};
    tbl[4] = '{6'd63, 2'b10, 1'b1, 32'hFFFF_FFFF};
    tbl[5] = '{6'd0,  2'b11, 1'b0, 32'h0000_0000};
    tbl[6] = '{6'd5,  2'b11, 1'b0, 32'h0000_0000};

    #1;
    chk("reset_uo_out", {24'd0, uo_out}, 32'h0000_0002);
    chk("reset_irq", {31'd0, user_interrupt}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      address     = tbl[i].addr;
      data_read_n = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'd0, data_ready}, {31'd0, tbl[i].ready});
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].data);
      tick();
    end
    idle_bus();

    // Full escalation: GRACE=3, PULSE=4.
    do_write(6'd0, 32'd3, 2'b01);
    do_write(6'd1, 32'd4, 2'b00);
    do_write(6'd2, 32'd1, 2'b10);
    cnt_warn = 0;
    cnt_pulse = 0;
    wdt_timeout = 1'b1;
    repeat (14) tick();
    chk("esc_warn_cycles", 32'(cnt_warn), 32'd4);
    chk("esc_pulse_cycles", 32'(cnt_pulse), 32'd4);
    read_check(6'd3, 32'h0000_0107, "esc_status_hold");
    wdt_timeout = 1'b0;
    tick();
    read_check(6'd3, 32'h0000_0104, "esc_status_idle");

    // Tap during the grace window.
    do_write(6'd0, 32'd10, 2'b10);
    cnt_warn = 0;
    cnt_pulse = 0;
    wdt_timeout = 1'b1;
    tick();
    repeat (4) tick();
    wdt_timeout = 1'b0;
    tick();
    repeat (3) tick();
    chk("tap_warn_cycles", 32'(cnt_warn), 32'd5);
    chk("tap_pulse_cycles", 32'(cnt_pulse), 32'd0);
    read_check(6'd3, 32'h0000_0104, "tap_status");

    // Unarmed timeout is ignored; arming enters WARN one cycle after armed updates.
    do_write(6'd2, 32'd0, 2'b10);
    wdt_timeout = 1'b1;
    cnt_warn = 0;
    repeat (100) tick();
    chk("unarmed_warn", 32'(cnt_warn), 32'd0);
    read_check(6'd3, 32'h0000_0100, "unarmed_status");
    do_write(6'd2, 32'd1, 2'b10);
    #1;
    chk("arm_first_cycle_irq", {31'd0, user_interrupt}, 32'd0);
    tick();
    #1;
    chk("arm_entry_irq", {31'd0, user_interrupt}, 32'd1);
    wdt_timeout = 1'b0;
    repeat (2) tick();

    // PULSE=0 and GRACE=0: one WARN cycle, one pulse cycle.
    do_write(6'd1, 32'd0, 2'b00);
    do_write(6'd0, 32'hFF00, 2'b00);
    read_check(6'd0, 32'd0, "grace_byte_zero_ext");
    cnt_warn = 0;
    cnt_pulse = 0;
    wdt_timeout = 1'b1;
    repeat (6) tick();
    chk("min_warn_cycles", 32'(cnt_warn), 32'd1);
    chk("min_pulse_cycles", 32'(cnt_pulse), 32'd1);
    wdt_timeout = 1'b0;
    tick();
    for (int e = 0; e < 256; e++) begin
      wdt_timeout = 1'b1;
      repeat (4) tick();
      wdt_timeout = 1'b0;
      tick();
    end
    read_check(6'd3, 32'h0000_FF04, "count_saturated");
    wdt_timeout = 1'b1;
    tick();
    address      = 6'd2;
    data_in      = 32'd3;
    data_write_n = 2'b10;
    tick();
    idle_bus();
    read_check(6'd3, 32'h0000_0006, "clear_beats_inc");
    wdt_timeout = 1'b0;
    tick();

    // Asynchronous reset in the middle of a pulse.
    do_write(6'd1, 32'd20, 2'b00);
    wdt_timeout = 1'b1;
    repeat (3) tick();
    #1;
    chk("pulse_active", {31'd0, uo_out[1]}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_release", {31'd0, uo_out[1]}, 32'd1);
    chk("async_irq", {31'd0, user_interrupt}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wdt_timeout = 1'b0;
    read_check(6'd0, 32'd1000, "post_reset_grace");
    read_check(6'd1, 32'd16, "post_reset_pulse");
    read_check(6'd3, 32'd0, "post_reset_status");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      idle_bus();
      if ($urandom_range(0, 9) == 0) wdt_timeout = ~wdt_timeout;
      r = $urandom_range(0, 19);
      d = $urandom;
      w = 2'($urandom_range(0, 2));
      if (r == 0) begin
        if (w == 2'b00) d[7:3] = '0;
        else d[15:3] = '0;
        address = 6'd0;
        data_in = d;
        data_write_n = w;
      end else if (r == 1) begin
        d[7:3] = '0;
        address = 6'd1;
        data_in = d;
        data_write_n = w;
      end else if (r == 2) begin
        d[0] = ($urandom_range(0, 3) != 0);
        d[1] = ($urandom_range(0, 7) == 0);
        address = 6'd2;
        data_in = d;
        data_write_n = w;
      end else if (r < 9) begin
        ra = 6'($urandom_range(0, 63));
        if (ra == 6'd2) ra = 6'd3;
        address = ra;
        data_read_n = w;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
